seq_mult_acc: RTL and testbench
===============================

// Module: seq_mult_acc
// PURPOSE
//  Parametrised iterative (shift-add, 1 bit/cycle) multiplier-accumulator; successor to the fixed 4x4 pipelined multiplier.
//  Adds operand width parameter, signed/unsigned mode, optional accumulate, and valid/ready handshakes on both sides.
//  Sits behind the tile I/O wrapper; wrapper maps ui_in/uio_in to operands+controls and result to uo_out/uio_out.
// PARAMETERS
//  WIDTH      4  operand width (2..16)
//  ACC_GUARD  4  extra accumulator bits above 2*WIDTH; ACC_W = 2*WIDTH+ACC_GUARD
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  ena          in   1      1 = run; 0 = freeze all state, in_ready=0, outputs hold
//  in_valid     in   1      operand/command valid
//  in_ready     out  1      block can accept (IDLE state and ena=1)
//  a            in   WIDTH  multiplicand
//  b            in   WIDTH  multiplier
//  signed_mode  in   1      1 = a,b two's complement; 0 = unsigned
//  acc_en       in   1      1 = result = acc + a*b; 0 = result = a*b
//  acc_clr      in   1      1 = treat accumulator as 0 for this op (with acc_en)
//  out_valid    out  1      result valid, held until out_ready
//  out_ready    in   1      consumer accepts result
//  result       out  ACC_W  product / accumulated sum, two's complement in signed mode
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): state=IDLE, acc=0, result=0, out_valid=0, in_ready=0 until first edge with ena=1, busy=0.
//  - FSM: IDLE -> CALC on accept (in_valid & in_ready); CALC -> DONE after WIDTH iterations; DONE -> IDLE on out_valid & out_ready.
//  - Accept at edge k registers a,b,mode,acc_en,acc_clr; operands converted to magnitudes + sign flag (signed_mode & (a[W-1]^b[W-1])).
//  - CALC: one multiplier bit per cycle, counter WIDTH-1 down to 0; magnitude product complete at edge k+WIDTH.
//  - Edge k+WIDTH+1: sign applied (negate if flag), sign/zero-extended to ACC_W, added to acc (or 0 if !acc_en or acc_clr);
//    acc and result updated, out_valid=1. Latency accept->out_valid = WIDTH+1 cycles exactly.
//  - acc updated only when acc_en=1; acc_en=0 ops leave acc untouched. Accumulator wraps modulo 2^ACC_W, no saturation.
//  - Most-negative operand: |-2^(W-1)| = 2^(W-1) fits WIDTH-bit unsigned; (-8)*(-8)=+64 exact for WIDTH=4.
//  - in_ready=0 in CALC and DONE; no accept in the cycle DONE->IDLE (next accept earliest one cycle later).
//  - Backpressure: in DONE with out_ready=0, result and out_valid hold stable indefinitely.
//  - ena=0 in any state: counter, datapath, state frozen; resumes exactly where stopped when ena=1.
//  - in_valid while in_ready=0: ignored, not queued.
//  - rst_n low mid-CALC/DONE: op aborted, all outputs to reset values immediately, acc cleared.
// STRUCTURE
//  - Package seq_mult_pkg: state enum {IDLE,CALC,DONE}, ACC_GUARD default, ACC_W function.
//  - Sub-module shift_add_core: magnitude shift-add datapath + bit counter (start/done); top holds FSM, sign logic, accumulator.
// TESTING (WIDTH=4, ACC_GUARD=4, ACC_W=12; check 5 cycles after accept)
//  1 unsigned a=3,b=2 -> result=0x006, out_valid exactly 5 cycles after accept; a=15,b=15 -> 0x0E1.
//  2 signed a=4'h8,b=4'h8 -> 0x040; a=4'hD(-3),b=5 -> 0xFF1 (-15); unsigned a=4'hD,b=5 -> 0x041.
//  3 acc_en+acc_clr a=7,b=5 -> 0x023; then acc_en a=3,b=2 -> 0x029; then acc_en=0 a=1,b=1 -> 0x001, next acc_en a=0,b=0 -> 0x029.
//  4 backpressure: out_ready=0 for 10 cycles -> result/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE.
//  5 ena=0 for 3 cycles mid-CALC -> latency becomes 8 cycles, result unchanged (7*5=0x023).
//  6 rst_n=0 two cycles into CALC -> out_valid=0, result=0, busy=0 immediately; next op 2*2 -> 0x004.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the iterative multiply-accumulate block.
package seq_mult_pkg;

  localparam int ACC_GUARD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// Unsigned shift-add multiplier core: one multiplier bit per enabled cycle, MSB first.
module shift_add_core #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;

  // MSB-first: shift the partial product left, then add the multiplicand if this bit is set.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = done_q;
    if (en) begin
      if (start) begin
        mcand_d  = mcand;
        mplier_d = mplier;
        prod_d   = '0;
        cnt_d    = CW'(WIDTH - 1);
        run_d    = 1'b1;
        done_d   = 1'b0;
      end else if (run_q) begin
        prod_d = {prod_q[2*WIDTH-2:0], 1'b0}
               + (mplier_q[cnt_q] ? {{WIDTH{1'b0}}, mcand_q} : {(2*WIDTH){1'b0}});
        if (cnt_q == '0) begin
          run_d  = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  // Operand and product registers carry no reset; they are always reloaded on start.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

  assign prod = prod_q;
  assign done = done_q;

endmodule

// File: rtl/seq_mult_acc.sv
// Iterative signed/unsigned multiply-accumulate with valid/ready handshakes on both sides.
module seq_mult_acc
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int ACC_GUARD = ACC_GUARD_DEF,
  localparam int ACC_W     = acc_w(WIDTH, ACC_GUARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);

  state_e             state_q, state_d;
  logic               armed_q, armed_d;
  logic               sign_q, sign_d;
  logic               acc_en_q, acc_en_d;
  logic               acc_clr_q, acc_clr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] core_prod;
  logic               core_done;
  logic [ACC_W-1:0]   signed_prod;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   sum;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v, input logic sm);
    return (sm && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [ACC_W-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                  input logic neg);
    logic [ACC_W-1:0] ext;
    ext = ACC_W'(mag);
    return neg ? -ext : ext;
  endfunction

  // in_ready stays low after reset until the first enabled edge.
  assign in_ready = (state_q == IDLE) && ena && armed_q;
  assign accept   = in_valid && in_ready;
  assign mag_a    = abs_mag(a, signed_mode);
  assign mag_b    = abs_mag(b, signed_mode);

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .start  (accept),
    .mcand  (mag_a),
    .mplier (mag_b),
    .prod   (core_prod),
    .done   (core_done)
  );

  assign signed_prod = apply_sign(core_prod, sign_q);
  assign addend      = (acc_en_q && !acc_clr_q) ? acc_q : '0;
  assign sum         = addend + signed_prod;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ena;
    sign_d      = sign_q;
    acc_en_d    = acc_en_q;
    acc_clr_d   = acc_clr_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = CALC;
            sign_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_en_d  = acc_en;
            acc_clr_d = acc_clr;
          end
        end
        CALC: begin
          // Finalise one cycle after the core completes its last bit.
          if (core_done) begin
            state_d     = DONE;
            result_d    = sum;
            out_valid_d = 1'b1;
            if (acc_en_q) acc_d = sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      sign_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      sign_q      <= sign_d;
      acc_en_q    <= acc_en_d;
      acc_clr_q   <= acc_clr_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_mult_acc.sv
// Directed self-checking bench for seq_mult_acc at WIDTH=4, ACC_GUARD=4.
module tb_seq_mult_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        signed_mode;
  logic        acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_acc #(
    .WIDTH     (4),
    .ACC_GUARD (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy)
  );

  // Drives one command and returns edges from accept to out_valid (99 on timeout, -1 if never accepted).
  task automatic issue_op(input logic [3:0] ia, input logic [3:0] ib, input logic sm,
                          input logic ae, input logic ac, input int stall, output int lat);
    int n;
    a = ia; b = ib; signed_mode = sm; acc_en = ae; acc_clr = ac;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (stall > 0 && lat == 2) begin
        ena = 1'b0;
        repeat (stall) begin
          @(posedge clk); #1; lat++;
        end
        ena = 1'b1;
      end
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (result !== 12'h000) begin errors++; $display("FAIL reset_result: got %03h expected 000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst_n = 1'b1; ena = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_before_edge: got %0b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_armed: got %0b expected 1", in_ready); end
  endtask

  task automatic test_unsigned();
    int lat;
    issue_op(4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL unsigned_3x2_latency: got %0d expected 5", lat); end
    checks++; if (result !== 12'h006) begin errors++; $display("FAIL unsigned_3x2: got %03h expected 006", result); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL done_flags: got busy=%0b in_ready=%0b expected busy=1 in_ready=0", busy, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL consume_idle: got out_valid=%0b busy=%0b expected 0 0", out_valid, busy); end
    issue_op(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL unsigned_15x15_latency: got %0d expected 5", lat); end
    checks++; if (result !== 12'h0E1) begin errors++; $display("FAIL unsigned_15x15: got %03h expected 0E1", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int lat;
    issue_op(4'h8, 4'h8, 1'b1, 1'b0, 1'b0, 0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL signed_m8xm8_latency: got %0d expected 5", lat); end
    checks++; if (result !== 12'h040) begin errors++; $display("FAIL signed_m8xm8: got %03h expected 040", result); end
    @(posedge clk); #1;
    issue_op(4'hD, 4'h5, 1'b1, 1'b0, 1'b0, 0, lat);
    checks++; if (result !== 12'hFF1) begin errors++; $display("FAIL signed_m3x5: got %03h expected FF1", result); end
    @(posedge clk); #1;
    issue_op(4'hD, 4'h5, 1'b0, 1'b0, 1'b0, 0, lat);
    checks++; if (result !== 12'h041) begin errors++; $display("FAIL unsigned_13x5: got %03h expected 041", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_accumulate();
    int lat;
    issue_op(4'd7, 4'd5, 1'b0, 1'b1, 1'b1, 0, lat);
    checks++; if (result !== 12'h023) begin errors++; $display("FAIL acc_clear_7x5: got %03h expected 023", result); end
    @(posedge clk); #1;
    issue_op(4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 0, lat);
    checks++; if (result !== 12'h029) begin errors++; $display("FAIL acc_add_3x2: got %03h expected 029", result); end
    @(posedge clk); #1;
    issue_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 0, lat);
    checks++; if (result !== 12'h001) begin errors++; $display("FAIL acc_bypass_1x1: got %03h expected 001", result); end
    @(posedge clk); #1;
    issue_op(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 0, lat);
    checks++; if (result !== 12'h029) begin errors++; $display("FAIL acc_preserved: got %03h expected 029", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    issue_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b0, 0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency: got %0d expected 5", lat); end
    checks++; if (result !== 12'h01B) begin errors++; $display("FAIL bp_9x3: got %03h expected 01B", result); end
    a = 4'hF; b = 4'hF;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 12'h01B || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got out_valid=%0b result=%03h in_ready=%0b busy=%0b expected 1 01B 0 1",
                 i, out_valid, result, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got out_valid=%0b busy=%0b in_ready=%0b expected 0 0 1", out_valid, busy, in_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_not_queued: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_ena_stall();
    int lat;
    issue_op(4'd7, 4'd5, 1'b0, 1'b0, 1'b0, 3, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ena_stall_latency: got %0d expected 8", lat); end
    checks++; if (result !== 12'h023) begin errors++; $display("FAIL ena_stall_result: got %03h expected 023", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int lat;
    int n;
    a = 4'd6; b = 4'd6; signed_mode = 1'b0; acc_en = 1'b1; acc_clr = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_precondition_busy: got %0b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (result !== 12'h000) begin errors++; $display("FAIL arst_result: got %03h expected 000", result); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_busy_ready: got busy=%0b in_ready=%0b expected 0 0", busy, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_op(4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL arst_next_latency: got %0d expected 5", lat); end
    checks++; if (result !== 12'h004) begin errors++; $display("FAIL arst_next_2x2_acc_cleared: got %03h expected 004", result); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_accumulate();
    test_backpressure();
    test_ena_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
